scmp_bus_responder: RTL



---
 rtl/scmp_bus_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/scmp_bus_responder.sv
// Memory-side responder for the SC/MP external bus: decodes ADS_n/RD_n/WR_n,
// latches the paged address and status flags, and serves an internal RAM.
module scmp_bus_responder #(
   parameter int unsigned MEM_AW  = 12,
   parameter logic [15:0] ROM_TOP = 16'h0400
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [11:0]       cpu_addr,
   input  logic [7:0]        cpu_d_o,
   input  logic              ads_n,
   input  logic              rd_n,
   input  logic              wr_n,
   output logic [7:0]        cpu_d_i,
   input  logic              host_we,
   input  logic [MEM_AW-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic              halt_o,
   output logic [15:0]       fetch_cnt,
   output logic [15:0]       cur_addr,
   output logic              proto_err,
   output logic              wp_err
);

   localparam int unsigned DEPTH = 1 << MEM_AW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_READ  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_commit;
   logic              w_proto_set;
   logic              w_cpu_we;
   logic              w_wp_set;
   logic              w_ram_rd;
   logic [15:0]       w_ads_addr;
   logic              r_flag_r;
   logic [7:0]        r_rdata;
   logic [7:0]        r_mem [DEPTH];

   assign w_ads_addr = {cpu_d_o[3:0], cpu_addr};
   assign w_ram_rd   = !ads_n && cpu_d_o[4];

   // A same-cycle host write wins over a CPU commit, silently.
   assign w_cpu_we = w_commit && !host_we && (cur_addr >= ROM_TOP);
   assign w_wp_set = w_commit && !host_we && (cur_addr <  ROM_TOP);

   // Read data is only driven onto the bus while in READ.
   assign cpu_d_i = (r_state == S_READ) ? r_rdata : 8'hFF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_proto_set = 1'b0;
      if (!ads_n) begin
         // A new address strobe abandons whatever cycle was in progress.
         w_state_nxt = S_ADDR;
         w_proto_set = !rd_n || !wr_n;
      end else if (!rd_n && !wr_n) begin
         w_proto_set = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_proto_set = !rd_n || !wr_n;
            end
            S_ADDR: begin
               if (!rd_n) begin
                  if (r_flag_r) w_state_nxt = S_READ;
                  else          w_proto_set = 1'b1;
               end else if (!wr_n) begin
                  if (!r_flag_r) begin
                     w_state_nxt = S_WRITE;
                     w_commit    = 1'b1;
                  end else begin
                     w_proto_set = 1'b1;
                  end
               end
            end
            S_READ: begin
               w_proto_set = !wr_n;
               if (rd_n) w_state_nxt = S_IDLE;
            end
            S_WRITE: begin
               w_proto_set = !rd_n;
               if (!wr_n) w_commit    = 1'b1;
               else       w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= 16'h0000;
         r_flag_r  <= 1'b0;
         halt_o    <= 1'b0;
         fetch_cnt <= 16'h0000;
         proto_err <= 1'b0;
         wp_err    <= 1'b0;
      end else begin
         halt_o <= !ads_n && cpu_d_o[7];
         if (!ads_n) begin
            cur_addr <= w_ads_addr;
            r_flag_r <= cpu_d_o[4];
            if (cpu_d_o[5]) fetch_cnt <= fetch_cnt + 16'd1;
         end
         if (w_proto_set) proto_err <= 1'b1;
         if (w_wp_set)    wp_err    <= 1'b1;
      end
   end

   // RAM is not reset; gating on rst_n drops any write coinciding with reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (host_we)       r_mem[host_addr]             <= host_wdata;
         else if (w_cpu_we) r_mem[cur_addr[MEM_AW-1:0]]  <= cpu_d_o;
         if (w_ram_rd)      r_rdata <= r_mem[w_ads_addr[MEM_AW-1:0]];
      end
   end

endmodule
